// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl
//  Purpose  : Multi-cycle control unit for the MIPS-subset CPU. A Moore FSM
//             that decodes the latched instruction, drives the ALU op code and
//             operand selects, and sequences the IR, memory, register-file
//             and PC write enables. beq is resolved from the ALU zero flag.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1  system clock, rising edge
//    rst        in   1  asynchronous active-high reset
//    opcode     in   6  IR[31:26], meaningful from DECODE onward
//    funct      in   6  IR[5:0]
//    zero       in   1  ALU zero flag
//    mem_ready  in   1  memory access completes this cycle
//    aluop      out  4  ALU operation
//    alusrca    out  1  ALU A select (0 PC, 1 reg A)
//    alusrcb    out  3  ALU B select
//    ir_we      out  1  instruction register load
//    mem_rd     out  1  memory read request
//    mem_wr     out  1  memory write request
//    iord       out  1  memory address select (0 PC, 1 ALUOut)
//    reg_we     out  1  register-file write
//    regdst     out  1  destination select (0 rt, 1 rd)
//    memtoreg   out  1  writeback select (0 ALUOut, 1 MDR)
//    pc_we      out  1  PC write
//    pcsrc      out  2  PC source select
//    err        out  1  sticky illegal-instruction flag
//    state      out  4  current FSM state (debug)
// ============================================================================
module mc_ctrl #(
    parameter logic RESET_ERR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] aluop,
    output logic       alusrca,
    output logic [2:0] alusrcb,
    output logic       ir_we,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       iord,
    output logic       reg_we,
    output logic       regdst,
    output logic       memtoreg,
    output logic       pc_we,
    output logic [1:0] pcsrc,
    output logic       err,
    output logic [3:0] state
);

    // ------------------------------------------------------------------
    // Opcode / funct encodings
    // ------------------------------------------------------------------
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_XOR   = 6'h26;

    // ALU operation codes
    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b0100;
    localparam logic [3:0] c_ALU_AND  = 4'b0001;
    localparam logic [3:0] c_ALU_OR   = 4'b0101;
    localparam logic [3:0] c_ALU_XOR  = 4'b0010;
    localparam logic [3:0] c_ALU_PASB = 4'b0110;

    // ALU B operand selects
    localparam logic [2:0] c_B_REG    = 3'b000;
    localparam logic [2:0] c_B_FOUR   = 3'b001;
    localparam logic [2:0] c_B_SEXT   = 3'b010;
    localparam logic [2:0] c_B_SEXT2  = 3'b011;
    localparam logic [2:0] c_B_ZEXT   = 3'b100;
    localparam logic [2:0] c_B_UPPER  = 3'b101;

    // PC source selects
    localparam logic [1:0] c_PC_ALU    = 2'b00;
    localparam logic [1:0] c_PC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PC_JUMP   = 2'b10;

    // ------------------------------------------------------------------
    // State encoding; codes 12-15 are never targeted but are recovered
    // from by the default arm below.
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_EXEC_I = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   err_q;
    logic   err_d;

    // ------------------------------------------------------------------
    // State and sticky error registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            err_q   <= RESET_ERR;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign state = state_q;
    assign err   = err_q;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = S_FETCH;
        err_d    = err_q;
        aluop    = c_ALU_ADD;
        alusrca  = 1'b0;
        alusrcb  = c_B_REG;
        ir_we    = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        iord     = 1'b0;
        reg_we   = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        pc_we    = 1'b0;
        pcsrc    = c_PC_ALU;

        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every cycle but only committed (together
                // with the IR load) once memory delivers the instruction.
                mem_rd  = 1'b1;
                alusrcb = c_B_FOUR;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                // Precompute the branch target into ALUOut speculatively.
                alusrcb = c_B_SEXT2;
                case (opcode)
                    c_OP_LW, c_OP_SW:            state_d = S_MEMADR;
                    c_OP_RTYPE:                  state_d = S_EXEC_R;
                    c_OP_BEQ:                    state_d = S_BRANCH;
                    c_OP_ADDI, c_OP_ORI, c_OP_LUI: state_d = S_EXEC_I;
                    c_OP_J:                      state_d = S_JUMP;
                    default: begin
                        state_d = S_FETCH;
                        err_d   = 1'b1;
                    end
                endcase
            end

            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = c_B_SEXT;
                if (opcode == c_OP_LW) begin
                    state_d = S_MEMRD;
                end else if (opcode == c_OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_MEMRD: begin
                mem_rd  = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end

            S_MEMWB: begin
                reg_we   = 1'b1;
                memtoreg = 1'b1;
            end

            S_MEMWR: begin
                mem_wr  = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? S_FETCH : S_MEMWR;
            end

            S_EXEC_R: begin
                alusrca = 1'b1;
                alusrcb = c_B_REG;
                state_d = S_RWB;
                case (funct)
                    c_FN_ADD: aluop = c_ALU_ADD;
                    c_FN_SUB: aluop = c_ALU_SUB;
                    c_FN_AND: aluop = c_ALU_AND;
                    c_FN_OR:  aluop = c_ALU_OR;
                    c_FN_XOR: aluop = c_ALU_XOR;
                    default: begin
                        // Unsupported funct: abandon the instruction so
                        // nothing is written back.
                        aluop   = c_ALU_ADD;
                        err_d   = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_RWB: begin
                reg_we = 1'b1;
                regdst = 1'b1;
            end

            S_BRANCH: begin
                // Compare rs and rt by subtraction; take the target held in
                // ALUOut only if they are equal.
                alusrca = 1'b1;
                alusrcb = c_B_REG;
                aluop   = c_ALU_SUB;
                pcsrc   = c_PC_ALUOUT;
                pc_we   = zero;
            end

            S_EXEC_I: begin
                alusrca = 1'b1;
                state_d = S_IWB;
                case (opcode)
                    c_OP_ORI: begin
                        alusrcb = c_B_ZEXT;
                        aluop   = c_ALU_OR;
                    end
                    c_OP_LUI: begin
                        alusrcb = c_B_UPPER;
                        aluop   = c_ALU_PASB;
                    end
                    default: begin
                        alusrcb = c_B_SEXT;
                        aluop   = c_ALU_ADD;
                    end
                endcase
            end

            S_IWB: begin
                reg_we = 1'b1;
            end

            S_JUMP: begin
                pcsrc = c_PC_JUMP;
                pc_we = 1'b1;
            end

            default: begin
                // Unreachable codes: all outputs stay at their defaults.
                state_d = S_FETCH;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl
//  Purpose  : Self-checking bench for mc_ctrl. Per-cycle vectors of inputs and
//             hand-derived expected outputs are applied from a table, followed
//             by hand-written reset-abort and sticky-error sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] aluop;
    logic       alusrca;
    logic [2:0] alusrcb;
    logic       ir_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       reg_we;
    logic       regdst;
    logic       memtoreg;
    logic       pc_we;
    logic [1:0] pcsrc;
    logic       err;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    mc_ctrl #(.RESET_ERR(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .aluop     (aluop),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .ir_we     (ir_we),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .iord      (iord),
        .reg_we    (reg_we),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .pc_we     (pc_we),
        .pcsrc     (pcsrc),
        .err       (err),
        .state     (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected bus layout:
    // {state[4], aluop[4], alusrca, alusrcb[3],
    //  ir_we, mem_rd, mem_wr, iord, reg_we, regdst, memtoreg, pc_we,
    //  pcsrc[2], err}
    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        mr;
        logic [22:0] exp;
    } vec_t;

    vec_t tbl[$];

    // ctl = {ir_we, mem_rd, mem_wr, iord, reg_we, regdst, memtoreg, pc_we}
    function automatic vec_t v(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic mr,
                               input logic [3:0] st, input logic [3:0] al,
                               input logic asa, input logic [2:0] asb,
                               input logic [7:0] ctl, input logic [1:0] pcs,
                               input logic e);
        vec_t r;
        r.op  = op;
        r.fn  = fn;
        r.z   = z;
        r.mr  = mr;
        r.exp = {st, al, asa, asb, ctl, pcs, e};
        return r;
    endfunction

    function automatic logic [22:0] got_bus();
        return {state, aluop, alusrca, alusrcb, ir_we, mem_rd, mem_wr, iord,
                reg_we, regdst, memtoreg, pc_we, pcsrc, err};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Structural invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (mem_wr && reg_we) begin
                errors++;
                $display("FAIL inv_memwr_regwe got=1 exp=0 state=%0d", state);
            end
            checks++;
            if (ir_we && state != 4'd0) begin
                errors++;
                $display("FAIL inv_irwe_fetch got=state%0d exp=state0", state);
            end
        end
    end

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic mr);
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = mr;
    endtask

    initial begin
        // ---------------- table ----------------
        // add $3,$1,$2
        tbl.push_back(v(6'h00, 6'h20, 0, 1, 4'd0,  4'b0000, 0, 3'b001, 8'b1100_0001, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h20, 0, 1, 4'd1,  4'b0000, 0, 3'b011, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h20, 0, 1, 4'd6,  4'b0000, 1, 3'b000, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h20, 0, 1, 4'd7,  4'b0000, 0, 3'b000, 8'b0000_1100, 2'b00, 0));
        // sub
        tbl.push_back(v(6'h00, 6'h22, 0, 1, 4'd0,  4'b0000, 0, 3'b001, 8'b1100_0001, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h22, 0, 1, 4'd1,  4'b0000, 0, 3'b011, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h22, 0, 1, 4'd6,  4'b0100, 1, 3'b000, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h22, 0, 1, 4'd7,  4'b0000, 0, 3'b000, 8'b0000_1100, 2'b00, 0));
        // and / or / xor (EXEC_R only matters; RWB identical)
        tbl.push_back(v(6'h00, 6'h24, 0, 1, 4'd0,  4'b0000, 0, 3'b001, 8'b1100_0001, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h24, 0, 1, 4'd1,  4'b0000, 0, 3'b011, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h24, 0, 1, 4'd6,  4'b0001, 1, 3'b000, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h25, 0, 1, 4'd7,  4'b0000, 0, 3'b000, 8'b0000_1100, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h25, 0, 1, 4'd0,  4'b0000, 0, 3'b001, 8'b1100_0001, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h25, 0, 1, 4'd1,  4'b0000, 0, 3'b011, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h25, 0, 1, 4'd6,  4'b0101, 1, 3'b000, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h26, 0, 1, 4'd7,  4'b0000, 0, 3'b000, 8'b0000_1100, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h26, 0, 1, 4'd0,  4'b0000, 0, 3'b001, 8'b1100_0001, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h26, 0, 1, 4'd1,  4'b0000, 0, 3'b011, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h26, 0, 1, 4'd6,  4'b0010, 1, 3'b000, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h26, 0, 1, 4'd7,  4'b0000, 0, 3'b000, 8'b0000_1100, 2'b00, 0));
        // lw with two wait cycles in MEMRD
        tbl.push_back(v(6'h23, 6'h00, 0, 1, 4'd0,  4'b0000, 0, 3'b001, 8'b1100_0001, 2'b00, 0));
        tbl.push_back(v(6'h23, 6'h00, 0, 1, 4'd1,  4'b0000, 0, 3'b011, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h23, 6'h00, 0, 1, 4'd2,  4'b0000, 1, 3'b010, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h23, 6'h00, 0, 0, 4'd3,  4'b0000, 0, 3'b000, 8'b0101_0000, 2'b00, 0));
        tbl.push_back(v(6'h23, 6'h00, 0, 0, 4'd3,  4'b0000, 0, 3'b000, 8'b0101_0000, 2'b00, 0));
        tbl.push_back(v(6'h23, 6'h00, 0, 1, 4'd3,  4'b0000, 0, 3'b000, 8'b0101_0000, 2'b00, 0));
        tbl.push_back(v(6'h23, 6'h00, 0, 1, 4'd4,  4'b0000, 0, 3'b000, 8'b0000_1010, 2'b00, 0));
        // sw with a fetch stall and a write stall
        tbl.push_back(v(6'h2B, 6'h00, 0, 0, 4'd0,  4'b0000, 0, 3'b001, 8'b0100_0000, 2'b00, 0));
        tbl.push_back(v(6'h2B, 6'h00, 0, 1, 4'd0,  4'b0000, 0, 3'b001, 8'b1100_0001, 2'b00, 0));
        tbl.push_back(v(6'h2B, 6'h00, 0, 1, 4'd1,  4'b0000, 0, 3'b011, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h2B, 6'h00, 0, 1, 4'd2,  4'b0000, 1, 3'b010, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h2B, 6'h00, 0, 0, 4'd5,  4'b0000, 0, 3'b000, 8'b0011_0000, 2'b00, 0));
        tbl.push_back(v(6'h2B, 6'h00, 0, 1, 4'd5,  4'b0000, 0, 3'b000, 8'b0011_0000, 2'b00, 0));
        // beq taken, then not taken
        tbl.push_back(v(6'h04, 6'h00, 1, 1, 4'd0,  4'b0000, 0, 3'b001, 8'b1100_0001, 2'b00, 0));
        tbl.push_back(v(6'h04, 6'h00, 1, 1, 4'd1,  4'b0000, 0, 3'b011, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h04, 6'h00, 1, 1, 4'd8,  4'b0100, 1, 3'b000, 8'b0000_0001, 2'b01, 0));
        tbl.push_back(v(6'h04, 6'h00, 0, 1, 4'd0,  4'b0000, 0, 3'b001, 8'b1100_0001, 2'b00, 0));
        tbl.push_back(v(6'h04, 6'h00, 0, 1, 4'd1,  4'b0000, 0, 3'b011, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h04, 6'h00, 0, 1, 4'd8,  4'b0100, 1, 3'b000, 8'b0000_0000, 2'b01, 0));
        // lui, ori, addi
        tbl.push_back(v(6'h0F, 6'h00, 0, 1, 4'd0,  4'b0000, 0, 3'b001, 8'b1100_0001, 2'b00, 0));
        tbl.push_back(v(6'h0F, 6'h00, 0, 1, 4'd1,  4'b0000, 0, 3'b011, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h0F, 6'h00, 0, 1, 4'd9,  4'b0110, 1, 3'b101, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h0F, 6'h00, 0, 1, 4'd10, 4'b0000, 0, 3'b000, 8'b0000_1000, 2'b00, 0));
        tbl.push_back(v(6'h0D, 6'h00, 0, 1, 4'd0,  4'b0000, 0, 3'b001, 8'b1100_0001, 2'b00, 0));
        tbl.push_back(v(6'h0D, 6'h00, 0, 1, 4'd1,  4'b0000, 0, 3'b011, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h0D, 6'h00, 0, 1, 4'd9,  4'b0101, 1, 3'b100, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h0D, 6'h00, 0, 1, 4'd10, 4'b0000, 0, 3'b000, 8'b0000_1000, 2'b00, 0));
        tbl.push_back(v(6'h08, 6'h00, 0, 1, 4'd0,  4'b0000, 0, 3'b001, 8'b1100_0001, 2'b00, 0));
        tbl.push_back(v(6'h08, 6'h00, 0, 1, 4'd1,  4'b0000, 0, 3'b011, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h08, 6'h00, 0, 1, 4'd9,  4'b0000, 1, 3'b010, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h08, 6'h00, 0, 1, 4'd10, 4'b0000, 0, 3'b000, 8'b0000_1000, 2'b00, 0));
        // j
        tbl.push_back(v(6'h02, 6'h00, 0, 1, 4'd0,  4'b0000, 0, 3'b001, 8'b1100_0001, 2'b00, 0));
        tbl.push_back(v(6'h02, 6'h00, 0, 1, 4'd1,  4'b0000, 0, 3'b011, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h02, 6'h00, 0, 1, 4'd11, 4'b0000, 0, 3'b000, 8'b0000_0001, 2'b10, 0));
        // illegal opcode 0x3F, then R-type with funct 0x00
        tbl.push_back(v(6'h3F, 6'h00, 0, 1, 4'd0,  4'b0000, 0, 3'b001, 8'b1100_0001, 2'b00, 0));
        tbl.push_back(v(6'h3F, 6'h00, 0, 1, 4'd1,  4'b0000, 0, 3'b011, 8'b0000_0000, 2'b00, 0));
        tbl.push_back(v(6'h00, 6'h00, 0, 1, 4'd0,  4'b0000, 0, 3'b001, 8'b1100_0001, 2'b00, 1));
        tbl.push_back(v(6'h00, 6'h00, 0, 1, 4'd1,  4'b0000, 0, 3'b011, 8'b0000_0000, 2'b00, 1));
        tbl.push_back(v(6'h00, 6'h00, 0, 1, 4'd6,  4'b0000, 1, 3'b000, 8'b0000_0000, 2'b00, 1));
        tbl.push_back(v(6'h00, 6'h00, 0, 0, 4'd0,  4'b0000, 0, 3'b001, 8'b0100_0000, 2'b00, 1));

        // ---------------- reset state ----------------
        rst = 1'b1;
        drive(6'h00, 6'h00, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("reset_state", {9'd0, got_bus()},
            {9'd0, 4'd0, 4'b0000, 1'b0, 3'b001, 8'b0100_0000, 2'b00, 1'b0});
        rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].mr);
            #1;
            chk($sformatf("vec[%0d]", i), {9'd0, got_bus()}, {9'd0, tbl[i].exp});
        end

        // ---------------- reset mid-MEMRD ----------------
        @(negedge clk); drive(6'h23, 6'h00, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); drive(6'h23, 6'h00, 1'b0, 1'b0);
        #1;
        chk("memrd_before_rst_state", {28'd0, state}, 32'd3);
        chk("err_sticky_before_rst", {31'd0, err}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_state", {28'd0, state}, 32'd0);
        chk("async_rst_err", {31'd0, err}, 32'd0);
        chk("async_rst_no_write", {30'd0, reg_we, mem_wr}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_held_no_write", {30'd0, reg_we, mem_wr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_fetch", {27'd0, state, mem_rd, iord}, {27'd0, 4'd0, 1'b1, 1'b0});

        // ---------------- illegal funct alone sets err ----------------
        drive(6'h00, 6'h3F, 1'b0, 1'b1);
        @(negedge clk); #1;
        chk("badfn_decode", {28'd0, state}, 32'd1);
        @(negedge clk); #1;
        chk("badfn_exec_r", {27'd0, state, err}, {27'd0, 4'd6, 1'b0});
        drive(6'h00, 6'h3F, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("badfn_to_fetch", {26'd0, state, err, reg_we}, {26'd0, 4'd0, 1'b1, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
